// File: rtl/ssb_if.sv
// Shared-system-bus signal bundle: host-side request/response lanes and the
// shared device-side request path. The slave modport is the interconnect view.
interface ssb_if #(
  parameter int unsigned NrHosts   = 3,
  parameter int unsigned NrDevices = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32
);
  logic [NrHosts-1:0]        host_req_i;
  logic [NrHosts-1:0]        host_gnt_o;
  logic [NrHosts*AW-1:0]     host_addr_i;
  logic [NrHosts-1:0]        host_we_i;
  logic [NrHosts*DW/8-1:0]   host_be_i;
  logic [NrHosts*DW-1:0]     host_wdata_i;
  logic [NrHosts-1:0]        host_rvalid_o;
  logic [NrHosts-1:0]        host_err_o;
  logic [DW-1:0]             host_rdata_o;
  logic [NrDevices-1:0]      dev_req_o;
  logic                      dev_we_o;
  logic [DW/8-1:0]           dev_be_o;
  logic [AW-1:0]             dev_addr_o;
  logic [DW-1:0]             dev_wdata_o;
  logic [NrDevices*DW-1:0]   dev_rdata_i;

  // Interconnect side.
  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i, dev_rdata_i,
    output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
           dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
  );

  // Environment side (hosts and devices together).
  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i, dev_rdata_i,
    input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
           dev_req_o, dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o
  );
endinterface

// File: rtl/ssb_arbiter.sv
// Shared-system-bus interconnect: N single-outstanding hosts onto M
// single-cycle-latency devices. Combinational arbitration and decode, one
// registered response stage routing rdata/err back to the granted host.
module ssb_arbiter #(
  parameter int unsigned NrHosts   = 3,
  parameter int unsigned NrDevices = 2,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned ArbMode   = 0,
  parameter logic [AW*NrDevices-1:0] DevBase = '0,
  parameter logic [AW*NrDevices-1:0] DevMask = '0
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  ssb_if.slave  bus
);
  localparam int unsigned HW   = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
  localparam int unsigned DevW = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [HW-1:0]   rr_ptr;
  logic [HW-1:0]   win_idx;
  logic [HW:0]     cand;
  logic            win_valid;
  logic            gnt_any;
  logic [AW-1:0]   sel_addr;
  logic [DevW-1:0] dev_idx;
  logic            hit_any;

  logic            rsp_valid;
  logic [HW-1:0]   rsp_host;
  logic [DevW-1:0] rsp_dev;
  logic            rsp_miss;
  logic            rsp_live;

  // Pick the winning requester: lowest index, or first at/after the RR pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (ArbMode == 0) begin
      for (int h = NrHosts - 1; h >= 0; h--) begin
        if (bus.host_req_i[h]) begin
          win_valid = 1'b1;
          win_idx   = HW'(h);
        end
      end
    end else begin
      for (int k = 0; k < NrHosts; k++) begin
        cand = {1'b0, rr_ptr} + (HW+1)'(k);
        if (cand >= (HW+1)'(NrHosts)) cand = cand - (HW+1)'(NrHosts);
        if (!win_valid && bus.host_req_i[cand[HW-1:0]]) begin
          win_valid = 1'b1;
          win_idx   = cand[HW-1:0];
        end
      end
    end
  end

  // Reset forces grants (and hence all device-side requests) low.
  assign gnt_any  = rst_ni && win_valid;
  assign sel_addr = bus.host_addr_i[win_idx*AW +: AW];

  // Base/mask decode of the winning address; lowest device wins on overlap.
  always_comb begin
    hit_any = 1'b0;
    dev_idx = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((sel_addr & ~DevMask[d*AW +: AW]) == DevBase[d*AW +: AW]) begin
        hit_any = 1'b1;
        dev_idx = DevW'(d);
      end
    end
  end

  // Drive grant and the shared device path from the winner; all zero when idle.
  always_comb begin
    bus.host_gnt_o  = '0;
    bus.dev_req_o   = '0;
    bus.dev_we_o    = 1'b0;
    bus.dev_be_o    = '0;
    bus.dev_addr_o  = '0;
    bus.dev_wdata_o = '0;
    if (gnt_any) begin
      bus.host_gnt_o[win_idx] = 1'b1;
      bus.dev_we_o    = bus.host_we_i[win_idx];
      bus.dev_be_o    = bus.host_be_i[win_idx*(DW/8) +: DW/8];
      bus.dev_addr_o  = sel_addr;
      bus.dev_wdata_o = bus.host_wdata_i[win_idx*DW +: DW];
      if (hit_any) bus.dev_req_o[dev_idx] = 1'b1;
    end
  end

  // Advance the round-robin pointer past each granted host.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments for registered state avoid simulation races.
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (gnt_any && ArbMode != 0) begin
      rr_ptr <= (win_idx == HW'(NrHosts - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Capture who was granted and where it went, for next-cycle response routing.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid <= 1'b0;
      rsp_host  <= '0;
      rsp_dev   <= '0;
      rsp_miss  <= 1'b0;
    end else begin
      rsp_valid <= gnt_any;
      rsp_host  <= win_idx;
      rsp_dev   <= dev_idx;
      rsp_miss  <= ~hit_any;
    end
  end

  // A response in flight when reset asserts is dropped immediately.
  assign rsp_live = rsp_valid && rst_ni;

  // Route the response pulse, error flag and device read data to the host.
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    bus.host_rdata_o  = '0;
    if (rsp_live) begin
      bus.host_rvalid_o[rsp_host] = 1'b1;
      if (rsp_miss) bus.host_err_o[rsp_host] = 1'b1;
      else          bus.host_rdata_o = bus.dev_rdata_i[rsp_dev*DW +: DW];
    end
  end
endmodule

// File: tb/tb_ssb_arbiter.sv
// Directed bench for ssb_arbiter: one fixed-priority and one round-robin
// instance driven with identical stimulus and compared against hand values.
module tb_ssb_arbiter;
  localparam int unsigned NH = 3;
  localparam int unsigned ND = 2;
  localparam logic [63:0] BASE = {32'h1A11_0000, 32'h0000_0000};
  localparam logic [63:0] MASK = {32'h0000_FFFF, 32'h0000_FFFF};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req;
  logic [95:0]   addr;
  logic [2:0]    we;
  logic [11:0]   be;
  logic [95:0]   wdata;
  logic [63:0]   rdata_dev;

  int total  = 0;
  int passed = 0;

  ssb_if #(.NrHosts(NH), .NrDevices(ND), .AW(32), .DW(32)) bus_f ();
  ssb_if #(.NrHosts(NH), .NrDevices(ND), .AW(32), .DW(32)) bus_r ();

  assign bus_f.host_req_i   = req;
  assign bus_f.host_addr_i  = addr;
  assign bus_f.host_we_i    = we;
  assign bus_f.host_be_i    = be;
  assign bus_f.host_wdata_i = wdata;
  assign bus_f.dev_rdata_i  = rdata_dev;
  assign bus_r.host_req_i   = req;
  assign bus_r.host_addr_i  = addr;
  assign bus_r.host_we_i    = we;
  assign bus_r.host_be_i    = be;
  assign bus_r.host_wdata_i = wdata;
  assign bus_r.dev_rdata_i  = rdata_dev;

  ssb_arbiter #(.NrHosts(NH), .NrDevices(ND), .AW(32), .DW(32), .ArbMode(0),
                .DevBase(BASE), .DevMask(MASK))
    u_fix (.clk_i(clk), .rst_ni(rst_n), .bus(bus_f));

  ssb_arbiter #(.NrHosts(NH), .NrDevices(ND), .AW(32), .DW(32), .ArbMode(1),
                .DevBase(BASE), .DevMask(MASK))
    u_rr (.clk_i(clk), .rst_ni(rst_n), .bus(bus_r));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_host(input int h, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    addr[h*32 +: 32]  = a;
    we[h]             = w;
    be[h*4 +: 4]      = b;
    wdata[h*32 +: 32] = d;
  endtask

  logic [2:0] rr_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst_n = 1'b0;
    req   = 3'b111;
    addr  = '0;
    we    = '0;
    be    = '0;
    wdata = '0;
    rdata_dev = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    for (int h = 0; h < 3; h++) set_host(h, 32'h0000_0010, 1'b0, 4'hF, 32'h0);

    // Grants and device requests are forced low during reset.
    #2;
    check("rst_gnt_f", bus_f.host_gnt_o, 3'b000);
    check("rst_gnt_r", bus_r.host_gnt_o, 3'b000);
    check("rst_devreq_r", bus_r.dev_req_o, 2'b00);
    step();
    check("rst_rvalid_r", bus_r.host_rvalid_o, 3'b000);
    check("rst_rdata_r", bus_r.host_rdata_o, 32'h0);
    rst_n = 1'b1;
    req   = 3'b000;
    #2;
    check("idle_addr", bus_r.dev_addr_o, 32'h0);

    // Tests 1 and 2: all hosts request continuously.
    step();
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #2;
      check("fix_gnt", bus_f.host_gnt_o, 3'b001);
      check("rr_gnt", bus_r.host_gnt_o, rr_exp[i]);
      if (i > 0) begin
        check("rr_rvalid", bus_r.host_rvalid_o, rr_exp[i-1]);
        check("fix_rvalid", bus_f.host_rvalid_o, 3'b001);
      end
      step();
    end
    req = 3'b000;
    #2;
    check("rr_rvalid_last", bus_r.host_rvalid_o, 3'b100);
    check("rr_rdata_last", bus_r.host_rdata_o, 32'hDEAD_BEEF);
    check("idle_gnt", bus_r.host_gnt_o, 3'b000);

    // Test 3: host 1 read of device 0 (RR pointer now 0).
    step();
    check("idle_rvalid", bus_r.host_rvalid_o, 3'b000);
    check("idle_rdata", bus_r.host_rdata_o, 32'h0);
    req = 3'b010;
    set_host(1, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    #2;
    check("t3_gnt", bus_r.host_gnt_o, 3'b010);
    check("t3_devreq", bus_r.dev_req_o, 2'b01);
    check("t3_addr", bus_r.dev_addr_o, 32'h0000_0010);
    step();
    req = 3'b000;
    #2;
    check("t3_rvalid", bus_r.host_rvalid_o, 3'b010);
    check("t3_rdata", bus_r.host_rdata_o, 32'hDEAD_BEEF);
    check("t3_err", bus_r.host_err_o, 3'b000);

    // Test 4: host 2 write to device 1 with partial byte enables.
    step();
    req = 3'b100;
    set_host(2, 32'h1A11_0004, 1'b1, 4'b0011, 32'h1234_5678);
    #2;
    check("t4_devreq", bus_r.dev_req_o, 2'b10);
    check("t4_be", bus_r.dev_be_o, 4'b0011);
    check("t4_we", bus_r.dev_we_o, 1'b1);
    check("t4_wdata", bus_r.dev_wdata_o, 32'h1234_5678);
    step();
    req = 3'b000;
    #2;
    check("t4_rvalid", bus_r.host_rvalid_o, 3'b100);
    check("t4_err", bus_r.host_err_o, 3'b000);
    check("t4_rdata", bus_r.host_rdata_o, 32'hCAFE_F00D);

    // Test 5: host 0 read of an unmapped address.
    step();
    req = 3'b001;
    set_host(0, 32'h8000_0000, 1'b0, 4'hF, 32'h0);
    #2;
    check("t5_gnt", bus_f.host_gnt_o, 3'b001);
    check("t5_devreq", bus_f.dev_req_o, 2'b00);
    check("t5_devreq_r", bus_r.dev_req_o, 2'b00);
    step();
    req = 3'b000;
    #2;
    check("t5_rvalid", bus_f.host_rvalid_o, 3'b001);
    check("t5_err", bus_f.host_err_o, 3'b001);
    check("t5_err_r", bus_r.host_err_o, 3'b001);
    check("t5_rdata", bus_f.host_rdata_o, 32'h0);

    // RR wrap: pointer is 1, hosts 0 and 2 request -> 2 then 0.
    step();
    set_host(0, 32'h0000_0010, 1'b0, 4'hF, 32'h0);
    req = 3'b101;
    #2;
    check("wrap_rr_a", bus_r.host_gnt_o, 3'b100);
    check("wrap_fix_a", bus_f.host_gnt_o, 3'b001);
    step();
    #2;
    check("wrap_rr_b", bus_r.host_gnt_o, 3'b001);

    // Test 6: reset in the cycle after a grant discards the response.
    step();
    req = 3'b010;
    #2;
    check("t6_gnt", bus_r.host_gnt_o, 3'b010);
    step();
    rst_n = 1'b0;
    req   = 3'b000;
    #2;
    check("t6_rvalid_rst_r", bus_r.host_rvalid_o, 3'b000);
    check("t6_rvalid_rst_f", bus_f.host_rvalid_o, 3'b000);
    step();
    rst_n = 1'b1;
    #2;
    check("t6_rvalid_post", bus_r.host_rvalid_o, 3'b000);
    req = 3'b111;
    #2;
    check("t6_ptr_zero", bus_r.host_gnt_o, 3'b001);
    step();
    req = 3'b000;
    #2;
    check("t6_rvalid_new", bus_r.host_rvalid_o, 3'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
